dsm_cic_decimator: RTL and testbench
====================================

// Module: dsm_cic_decimator
// PURPOSE
//  Receive end of the DSM_top 3-level pwm stream: decodes the 2-bit symbol per clock, low-pass
//  filters and decimates it with an ORDER-stage CIC (integrators at clock rate, combs at 1/2^LOG2R),
//  and outputs reconstructed samples in the DSM 20-bit voltage format (bit 15 = 1 V, 0x04000 = 0.5 V).
//  Used as the loopback checker/demodulator for the modulator and as the first decimation stage.
// PARAMETERS
//  ORDER  3  number of integrator and comb stages (legal 1..4)
//  LOG2R  6  log2 of decimation ratio R = 2^LOG2R (legal 4..8)
// PORTS
//  clock      in   1   rising-edge clock, same clock as the modulator
//  reset      in   1   synchronous, active-high
//  pwm        in   2   DSM symbol: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = illegal
//  pwm_valid  in   1   pwm sampled only when high (clock enable)
//  dout       out  20  reconstructed sample, two's complement, 0x04000 = +0.5 V
//  dout_valid out  1   one-cycle strobe, dout updated in same cycle
//  err        out  1   sticky: an illegal symbol was received since reset
// BEHAVIOUR
//  Widths: W = ORDER*LOG2R + 2; all integrator/comb/delay regs W-bit signed; integrator overflow
//   wraps modulo 2^W (intended, exact for CIC); no saturation anywhere.
//  Decode: x = +1 / 0 / -1 (sign-extended to W) per symbol table; 2'b10 decodes as 0 and sets err.
//  Reset: all integrators, comb delays, decimation counter, warm-up counter, dout, dout_valid, err
//   cleared to 0 at the first rising edge with reset=1; reset mid-operation discards all history.
//  Integrators (only on pwm_valid=1): I1 <= I1 + x; Ik <= Ik + I(k-1) using the registered (old)
//   value of I(k-1), k = 2..ORDER. pwm_valid=0: every register holds, counter does not advance.
//  Decimation counter cnt (LOG2R bits) increments on each pwm_valid; tick = pwm_valid & (cnt == R-1);
//   cnt wraps R-1 -> 0 on the tick.
//  Comb chain on tick, combinational from current (pre-update) I_ORDER: C0 = I_ORDER;
//   Ck = C(k-1) - Dk; Dk <= C(k-1) (updated only on tick), k = 1..ORDER.
//  Scaling: gain R^ORDER = 2^(ORDER*LOG2R); S = ORDER*LOG2R - 14. dout = C_ORDER >>> S if S >= 0,
//   else C_ORDER <<< -S; then sign-extended/truncated to 20 bits. Full scale +/-1 symbol -> +/-0x04000.
//  Output: on tick dout <= scaled value, registered; dout_valid high the cycle after the tick.
//   Latency tick -> dout_valid = 1 clock. dout holds between strobes.
//  Warm-up: first ORDER ticks after reset update combs/dout but keep dout_valid=0 (transient);
//   first dout_valid follows tick ORDER+1, i.e. the cycle after the (ORDER+1)*R-th valid sample.
//  err: set the cycle after a pwm_valid=1 with pwm=2'b10; cleared only by reset.
//  Simultaneous reset and tick: reset wins, no strobe.
// TESTING
//  1 reset, pwm=00 continuous, pwm_valid=1 -> first dout_valid after 256 valid samples (defaults),
//    dout=0x00000, then strobe every 64 clocks, err=0.
//  2 pwm=01 continuous -> every dout_valid has dout=0x04000; pwm=11 continuous -> dout=0xFC000.
//  3 alternating 01,00 -> steady dout=0x02000; alternating 01,11 -> dout=0x00000; step 00->01
//    -> monotone rise reaching 0x04000 within ORDER+1 strobes.
//  4 pwm_valid toggled 1,0,1,0 with constant 01 -> strobe spacing 128 clocks, dout=0x04000, values
//    identical to gap-free run.
//  5 single pwm=10 in constant 00 stream -> err=1 next cycle and stays 1, dout stays 0x00000;
//    reset -> err=0.
//  6 reset asserted mid-frame with integrators near wrap (long 01 run) -> all outputs 0 next cycle,
//    warm-up restarts, no strobe for next 256 valid samples; compare vs bit-true model with
//    ORDER=4, LOG2R=4 (S=2) too.

Source files
------------

// File: rtl/dsm_cic_decimator.sv
// CIC decimator for the 3-level DSM stream: symbol decode, ORDER integrators at clock rate,
// ORDER combs at 1/2^LOG2R, scaled to the 20-bit DSM voltage format (0x04000 = 0.5 V).
module dsm_cic_decimator #(
  parameter int ORDER = 3,
  parameter int LOG2R = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pwm,
  input  logic        pwm_valid,
  output logic [19:0] dout,
  output logic        dout_valid,
  output logic        err
);

  localparam int W  = ORDER * LOG2R + 2;
  localparam int S  = ORDER * LOG2R - 14;
  localparam int unsigned SR = (S >= 0) ? S : 0;
  localparam int unsigned SL = (S < 0) ? -S : 0;
  // Headroom so a left shift (small ORDER*LOG2R) cannot drop significant bits before truncation.
  localparam int XW = W + 20;
  localparam logic [LOG2R-1:0] CNT_LAST = '1;
  localparam logic [2:0]       WARM_DONE = 3'(ORDER);

  logic signed [W-1:0]  integ_q [ORDER];
  logic signed [W-1:0]  integ_d [ORDER];
  logic signed [W-1:0]  dly_q   [ORDER];
  logic signed [W-1:0]  comb    [ORDER+1];
  logic [LOG2R-1:0]     cnt_q;
  logic [2:0]           warm_q;
  logic [19:0]          dout_q;
  logic                 dv_q;
  logic                 err_q;
  logic signed [W-1:0]  x;
  logic                 tick;
  logic                 bad;
  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] scaled;

  always_comb begin
    x = '0;
    case (pwm)
      2'b01:   x = W'(1);
      2'b11:   x = '1;
      default: x = '0;
    endcase
  end

  assign bad  = pwm_valid && (pwm == 2'b10);
  assign tick = pwm_valid && (cnt_q == CNT_LAST);

  // Each stage accumulates the registered (previous) value of the stage before it.
  always_comb begin
    integ_d[0] = integ_q[0] + x;
    for (int unsigned k = 1; k < ORDER; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_comb begin
    comb[0] = integ_q[ORDER-1];
    for (int unsigned k = 0; k < ORDER; k++) begin
      comb[k+1] = comb[k] - dly_q[k];
    end
    ext    = XW'(comb[ORDER]);
    scaled = (ext >>> SR) <<< SL;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      cnt_q  <= '0;
      warm_q <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (bad) begin
        err_q <= 1'b1;
      end
      if (pwm_valid) begin
        for (int unsigned k = 0; k < ORDER; k++) begin
          integ_q[k] <= integ_d[k];
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if (tick) begin
        for (int unsigned k = 0; k < ORDER; k++) begin
          dly_q[k] <= comb[k];
        end
        dout_q <= 20'(scaled);
        // The first ORDER decimated outputs are filter fill transient and are not strobed.
        if (warm_q == WARM_DONE) begin
          dv_q <= 1'b1;
        end else begin
          warm_q <= warm_q + 1'b1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Bench for dsm_cic_decimator: two instances (3/6 and 4/4) against a convolution-based CIC model.
module tb_dsm_cic_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pwm = 2'b00;
  logic        pwm_valid = 1'b0;
  logic [19:0] dout_a, dout_b;
  logic        dv_a, dv_b, err_a, err_b;

  always #5 clk = ~clk;

  dsm_cic_decimator #(.ORDER(3), .LOG2R(6)) u_a (
    .clock(clk), .reset(reset), .pwm(pwm), .pwm_valid(pwm_valid),
    .dout(dout_a), .dout_valid(dv_a), .err(err_a)
  );

  dsm_cic_decimator #(.ORDER(4), .LOG2R(4)) u_b (
    .clock(clk), .reset(reset), .pwm(pwm), .pwm_valid(pwm_valid),
    .dout(dout_b), .dout_valid(dv_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: impulse response of an N-stage CIC is boxcar(R) convolved N times, delayed N samples.
  int     ordv [2] = '{3, 4};
  int     lrv  [2] = '{6, 4};
  longint h    [2][256];
  longint tmp  [256];
  int     hlen [2];
  int     hist [$];
  int     ktick [2];
  logic [19:0] e_dout [2];
  logic        e_dv [2];
  logic        e_err;
  bit          armed = 0;
  int          cyc = 0, last_strobe = 0, gap_a = 0, strobes_a = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      int r;
      r = 1 << lrv[i];
      for (int j = 0; j < 256; j++) h[i][j] = 0;
      h[i][0] = 1;
      hlen[i] = 1;
      for (int s = 0; s < ordv[i]; s++) begin
        for (int j = 0; j < 256; j++) tmp[j] = 0;
        for (int j = 0; j < hlen[i]; j++)
          for (int a = 0; a < r; a++) tmp[j+a] += h[i][j];
        hlen[i] += r - 1;
        for (int j = 0; j < 256; j++) h[i][j] = tmp[j];
      end
    end
  end

  function automatic logic [19:0] model_out(input int i);
    longint      y;
    int          base, idx, s;
    logic [63:0] v;
    y    = 0;
    base = hist.size() - 1 - ordv[i];
    s    = ordv[i] * lrv[i] - 14;
    for (int j = 0; j < hlen[i]; j++) begin
      idx = base - j;
      if (idx >= 0) y += h[i][j] * hist[idx];
    end
    if (s >= 0) y = y >>> s;
    else        y = y <<< (-s);
    v = y;
    return v[19:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      ktick  = '{0, 0};
      e_dout = '{20'h0, 20'h0};
      e_dv   = '{1'b0, 1'b0};
      e_err  = 1'b0;
      armed  = 1;
    end else if (armed) begin
      e_dv[0] = 1'b0;
      e_dv[1] = 1'b0;
      if (pwm_valid) begin
        if (pwm == 2'b10) e_err = 1'b1;
        hist.push_back(pwm == 2'b01 ? 1 : (pwm == 2'b11 ? -1 : 0));
        for (int i = 0; i < 2; i++) begin
          if (hist.size() % (1 << lrv[i]) == 0) begin
            ktick[i]++;
            e_dout[i] = model_out(i);
            e_dv[i]   = (ktick[i] > ordv[i]);
          end
        end
      end
    end
    #1;
    cyc++;
    if (armed) begin
      chk("dout_a", dout_a, e_dout[0]);
      chk("dv_a",   20'(dv_a),  20'(e_dv[0]));
      chk("err_a",  20'(err_a), 20'(e_err));
      chk("dout_b", dout_b, e_dout[1]);
      chk("dv_b",   20'(dv_b),  20'(e_dv[1]));
      chk("err_b",  20'(err_b), 20'(e_err));
      if (dv_a) begin
        gap_a       = cyc - last_strobe;
        last_strobe = cyc;
        strobes_a++;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the last sample was clocked.
  task automatic run(input logic [1:0] s0, input logic [1:0] s1, input bit gap, input int n);
    for (int k = 0; k < n; k++) begin
      pwm       = (k % 2 == 0) ? s0 : s1;
      pwm_valid = 1'b1;
      @(negedge clk);
      if (gap) begin
        pwm_valid = 1'b0;
        pwm       = 2'b10;
        @(negedge clk);
      end
    end
    pwm_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pwm_valid = 1'b1;
    pwm       = 2'b01;
    @(negedge clk);
    reset     = 1'b0;
    pwm_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_dout", dout_a, 20'h0);
    chk("reset_dv", 20'(dv_a), 20'h0);

    // Zero stream: first strobe after 256 samples, then every 64 clocks.
    s0 = strobes_a;
    run(2'b00, 2'b00, 0, 255);
    chk("no_early_strobe", 20'(strobes_a - s0), 20'h0);
    run(2'b00, 2'b00, 0, 1);
    chk("first_strobe", 20'(dv_a), 20'h1);
    chk("first_dout", dout_a, 20'h0);
    run(2'b00, 2'b00, 0, 128);
    chk("spacing_64", 20'(gap_a), 20'd64);

    // Full scale.
    run(2'b01, 2'b01, 0, 512);
    chk("pos_fs_a", dout_a, 20'h04000);
    chk("pos_fs_b", dout_b, 20'h04000);
    run(2'b11, 2'b11, 0, 512);
    chk("neg_fs_a", dout_a, 20'hFC000);
    chk("neg_fs_b", dout_b, 20'hFC000);

    // Alternating patterns and a step.
    run(2'b01, 2'b00, 0, 512);
    chk("half_a", dout_a, 20'h02000);
    chk("half_b", dout_b, 20'h02000);
    run(2'b01, 2'b11, 0, 512);
    chk("zero_avg_a", dout_a, 20'h0);
    run(2'b00, 2'b00, 0, 512);
    run(2'b01, 2'b01, 0, 80);
    chk("step_b_5strobes", dout_b, 20'h04000);
    run(2'b01, 2'b01, 0, 176);
    chk("step_a_4strobes", dout_a, 20'h04000);

    // Clock-enable gaps stretch strobe spacing, values unchanged.
    run(2'b01, 2'b01, 1, 256);
    chk("spacing_128", 20'(gap_a), 20'd128);
    chk("gap_dout_a", dout_a, 20'h04000);

    // Illegal symbol: sticky err, decodes as zero.
    run(2'b00, 2'b00, 0, 300);
    chk("err_clear", 20'(err_a), 20'h0);
    run(2'b10, 2'b10, 0, 1);
    chk("err_set_a", 20'(err_a), 20'h1);
    chk("err_set_b", 20'(err_b), 20'h1);
    run(2'b00, 2'b00, 0, 200);
    chk("err_sticky", 20'(err_a), 20'h1);
    chk("err_dout", dout_a, 20'h0);
    do_reset();
    chk("err_reset", 20'(err_a), 20'h0);

    // Long +1 run (integrators wrap), reset coinciding with a tick.
    run(2'b01, 2'b01, 0, 1023);
    do_reset();
    chk("mid_reset_dout_a", dout_a, 20'h0);
    chk("mid_reset_dout_b", dout_b, 20'h0);
    chk("mid_reset_dv", 20'(dv_a), 20'h0);
    s0 = strobes_a;
    run(2'b01, 2'b01, 0, 255);
    chk("warmup_restart", 20'(strobes_a - s0), 20'h0);
    run(2'b01, 2'b01, 0, 1);
    chk("warmup_strobe", 20'(dv_a), 20'h1);
    chk("warmup_dout_a", dout_a, 20'h04000);
    chk("warmup_dout_b", dout_b, 20'h04000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
